// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_c
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = i_a ^ i_b;
    assign ha0_c = i_a & i_b;
    assign o_s   = ha0_s ^ i_ci;
    assign ha1_c = ha0_s & i_ci;
    assign o_c   = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands, adds them LSB-first through
// one full-adder cell with a registered carry, then reports sum/carry with a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_res_q, sh_res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;

    logic             sbit;
    logic             cbit;
    logic [WIDTH-1:0] res_next;

    fa_bit u_fa (
        .i_a  (sh_a_q[0]),
        .i_b  (sh_b_q[0]),
        .i_ci (carry_q),
        .o_s  (sbit),
        .o_c  (cbit)
    );

    // Result register with the current sum bit shifted in at the MSB.
    assign res_next = {sbit, sh_res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_res_d = sh_res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        s_d      = s_q;
        c_d      = c_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    sh_a_d  = i_a;
                    sh_b_d  = i_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d  = cbit;
                sh_res_d = res_next;
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                busy_d   = 1'b1;
                if (cnt_q == CntLast) begin
                    s_d     = res_next;
                    c_d     = cbit;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_res_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_q      <= '0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            sh_res_q <= sh_res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_q      <= s_d;
            c_q      <= c_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_s    = s_q;
    assign o_c    = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic a+b reference model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_s;
    logic         o_c;

    int total;
    int bad;

    // Last completed result as seen by the model; held on the outputs during RUN.
    logic [W-1:0] prev_s;
    logic         prev_c;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_s     (o_s),
        .o_c     (o_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Launch one addition from IDLE and check timing, held outputs and the result.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_a = ~a;
        i_b = ~b;
        for (int n = 1; n <= int'(W); n++) begin
            check("busy_run", 64'(o_busy), 64'(1));
            check("done_run", 64'(o_done), 64'(0));
            check("held_s", 64'(o_s), 64'(prev_s));
            check("held_c", 64'(o_c), 64'(prev_c));
            if (n < int'(W)) @(negedge clk);
        end
        @(negedge clk);
        check("done_pulse", 64'(o_done), 64'(1));
        check("busy_done", 64'(o_busy), 64'(0));
        check("sum", 64'(o_s), 64'(sum[W-1:0]));
        check("carry", 64'(o_c), 64'(sum[W]));
        prev_s = sum[W-1:0];
        prev_c = sum[W];
        @(negedge clk);
        check("done_one_cycle", 64'(o_done), 64'(0));
        check("busy_idle", 64'(o_busy), 64'(0));
    endtask

    // Wait for o_done sampled on negedges; reports cycles waited, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 60);
        if (!o_done) check("done_timeout", 64'(o_done), 64'(1));
    endtask

    initial begin
        int n1;
        int n2;
        total   = 0;
        bad     = 0;
        prev_s  = '0;
        prev_c  = 1'b0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_s", 64'(o_s), 64'(0));
        check("rst_c", 64'(o_c), 64'(0));
        i_rst = 1'b0;

        // Directed sums, including overflow and the all-ones case.
        run_add(8'd3, 8'd5);
        run_add(8'd255, 8'd1);
        run_add(8'd255, 8'd255);
        run_add(8'd0, 8'd0);

        // Start held high: two back-to-back runs at the WIDTH+2 period.
        @(negedge clk);
        i_a = 8'd10;
        i_b = 8'd20;
        i_start = 1'b1;
        @(negedge clk);
        i_a = 8'd100;
        i_b = 8'd27;
        wait_done(n1);
        check("held_start_lat", 64'(n1), 64'(W));
        check("held_start_s1", 64'(o_s), 64'(30));
        check("held_start_c1", 64'(o_c), 64'(0));
        wait_done(n2);
        i_start = 1'b0;
        check("done_spacing", 64'(n2), 64'(W + 2));
        check("held_start_s2", 64'(o_s), 64'(127));
        check("held_start_c2", 64'(o_c), 64'(0));
        prev_s = 8'd127;
        prev_c = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulsed during RUN with new operands: ignored, no second run.
        i_a = 8'd7;
        i_b = 8'd9;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        i_a = 8'd200;
        i_b = 8'd200;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(n1);
        check("ignore_start_s", 64'(o_s), 64'(16));
        check("ignore_start_c", 64'(o_c), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_second_run", 64'(o_busy), 64'(0));
        end
        prev_s = 8'd16;
        prev_c = 1'b0;

        // Reset in the middle of RUN aborts without a done pulse.
        i_a = 8'd100;
        i_b = 8'd100;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 64'(o_busy), 64'(1));
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_s", 64'(o_s), 64'(0));
        check("abort_c", 64'(o_c), 64'(0));
        prev_s = '0;
        prev_c = 1'b0;
        for (int i = 0; i < int'(W) + 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(o_done), 64'(0));
        end
        run_add(8'd1, 8'd1);

        // Reset and start on the same edge: reset wins, nothing captured.
        @(negedge clk);
        i_a = 8'd50;
        i_b = 8'd60;
        i_rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        check("rst_start_busy", 64'(o_busy), 64'(0));
        check("rst_start_s", 64'(o_s), 64'(0));
        @(negedge clk);
        check("rst_start_idle", 64'(o_busy), 64'(0));
        prev_s = '0;
        prev_c = 1'b0;

        for (int i = 0; i < 200; i++) begin
            run_add(W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer built around one 1-bit full-adder datapath, itself composed of two half-adder cells and an OR.
- Captures two WIDTH-bit operands on a start request.
- Feeds the operands LSB-first through the datapath, one bit per clock, with a registered carry.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency; it is the lab's sequential successor to the combinational adder cells.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
i_clk  input  1  system clock; all state on rising edge.
i_rst  input  1  synchronous, active-high reset.
i_start  input  1  request to begin an addition; honoured only in IDLE.
i_a  input  WIDTH  operand A, sampled on the accepting edge only.
i_b  input  WIDTH  operand B, sampled on the accepting edge only.
o_busy  output  1  high while in RUN.
o_done  output  1  one-cycle pulse; o_s/o_c valid from this cycle.
o_s  output  WIDTH  sum result, registered, held until next completion.
o_c  output  1  carry-out result, registered, held until next completion.

Behaviour:
- Clocking and reset: single clock domain; i_rst is synchronous and active-high, sampled on the i_clk rising edge.
- Reset values: state=IDLE; o_busy=0; o_done=0; o_s=0; o_c=0; bit counter=0; internal carry=0; shift registers=0.
- States: IDLE, RUN, DONE. All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE:
  - o_busy=0, o_done=0.
  - If i_start=1 at an edge: load i_a→sh_a, i_b→sh_b, carry←0, cnt←0, state←RUN.
- RUN (exactly WIDTH cycles):
  - Per edge: sbit=sh_a[0]^sh_b[0]^carry; carry←majority(sh_a[0],sh_b[0],carry).
  - sh_res←{sbit, sh_res[WIDTH-1:1]}; sh_a, sh_b shift right by 1 with zero fill; cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: o_s←final sh_res value (including this bit), o_c←new carry, o_done←1, state←DONE.
- DONE (one cycle): o_done=1, o_busy=0. Next edge: o_done←0, state←IDLE.
- Latency: start accepted at edge k → o_done high in the cycle after edge k+WIDTH. Back-to-back throughput is one result per WIDTH+2 cycles.
- Counter width: $clog2(WIDTH). Bits beyond WIDTH never wrap, since the terminal count ends RUN.
- Boundary conditions:
  - i_start in RUN or DONE: ignored, with no queuing. The requester must hold or re-assert it in IDLE.
  - i_start held high continuously: a new run starts in each IDLE cycle, giving the period above.
  - i_a/i_b changes after acceptance: no effect on the current run.
  - Overflow: sum modulo 2^WIDTH on o_s, with the overflow bit on o_c. Example: all-ones + all-ones gives o_s = all-ones minus 1, o_c=1.
  - i_rst asserted mid-RUN or in DONE: abort at that edge, all state and outputs go to reset values, and no o_done pulse is produced.
  - i_rst and i_start high at the same edge: reset wins; IDLE next cycle with no operand capture.
  - o_s/o_c are unchanged during RUN (previous result held) and update only on the completing edge.

Decomposition:
- Package serial_add_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- One sub-module, fa_bit: combinational 1-bit full adder (ports i_a, i_b, i_ci, o_s, o_c), built from two half-adder stages. The datapath bit is instantiated from it, not inlined.
- The FSM, counter and shift registers live in serial_add_ctrl.

Test Plan:
1. Reset 3 cycles, then i_a=3, i_b=5, i_start pulse (WIDTH=8) → o_busy high 8 cycles, o_done pulse 8 cycles after the accepting edge, o_s=8, o_c=0.
2. i_a=255, i_b=1 → o_s=0, o_c=1. Then i_a=255, i_b=255 → o_s=254, o_c=1. Then i_a=0, i_b=0 → o_s=0, o_c=0, and the previous result is held during RUN.
3. i_start held high, operands 10+20 then 100+27 → results 30 then 127, o_done pulses spaced exactly 10 cycles apart.
4. Start with 7+9, then set i_a=200, i_b=200 and pulse i_start during RUN → o_s=16, o_c=0, and no second run is launched.
5. Start 100+100, assert i_rst at RUN cycle 4 → no o_done; o_s=0, o_c=0, o_busy=0 the next cycle. A fresh start of 1+1 then yields o_s=2.
6. Randomised 200 operand pairs against a reference a+b → {o_c,o_s} matches each time, and o_done only ever lasts one cycle.
